// File: rtl/alu_issue.sv
// alu_issue: instruction issue and writeback sequencer for a combinational ALU.
//   - in_valid/in_ready/in_instr : instruction stream into a DEPTH-entry FIFO
//   - ld_en/ld_sel/ld_data       : direct load of regA (sel=0) or regB (sel=1)
//   - alu_instruction/alu_regA/alu_regB : operands driven to the ALU
//   - alu_result/alu_flags       : ALU response, flags = {zero, negative, overflow}
//   - out_valid/out_ready/out_*  : retired instruction with its captured result and flags
//   - reg_a/reg_b                : architectural registers
//   - retired                    : wrapping count of issued instructions
module alu_issue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             ld_en,
  input  logic             ld_sel,
  input  logic [31:0]      ld_data,
  output logic [31:0]      alu_instruction,
  output logic [31:0]      alu_regA,
  output logic [31:0]      alu_regB,
  input  logic [31:0]      alu_result,
  input  logic [2:0]       alu_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_result,
  output logic [2:0]       out_flags,
  output logic [31:0]      reg_a,
  output logic [31:0]      reg_b,
  output logic [CNT_W-1:0] retired
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][31:0] mem;
  logic [AW:0]            wr_ptr, rd_ptr;  // extra MSB tells full from empty
  logic                   empty, full, push, issue;
  logic [31:0]            head;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign issue    = !empty && (!out_valid || out_ready);
  assign head     = mem[rd_ptr[AW-1:0]];

  assign alu_instruction = empty ? 32'h0 : head;
  assign alu_regA        = reg_a;
  assign alu_regB        = reg_b;

  // Writeback decode of the head instruction
  logic [5:0]  opcode, funct;
  logic [4:0]  dst;
  logic        is_r, is_i, is_slt, ovf_op, wb_en, wb_sel;
  logic [31:0] wb_val;

  assign opcode = head[31:26];
  assign funct  = head[5:0];
  assign is_r   = (opcode == 6'b000000);
  assign is_i   = (opcode >= 6'b001000) && (opcode <= 6'b001110);
  assign dst    = is_r ? head[15:11] : head[20:16];
  assign is_slt = (is_r && (funct == 6'b101010 || funct == 6'b101011)) ||
                  opcode == 6'b001010 || opcode == 6'b001011;
  assign ovf_op = (is_r && (funct == 6'b100000 || funct == 6'b100010)) ||
                  opcode == 6'b001000;
  // Only indices 0/1 map to real registers; trapping arithmetic leaves the target untouched
  assign wb_en  = issue && (is_r || is_i) && (dst[4:1] == 4'b0) &&
                  !(ovf_op && alu_flags[0]);
  assign wb_sel = dst[0];
  assign wb_val = is_slt ? {31'b0, alu_flags[1]} : alu_result;

  // Storage needs no reset: the pointers define which entries are live
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_instr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_result <= '0;
      out_flags  <= '0;
      reg_a      <= '0;
      reg_b      <= '0;
      retired    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (issue) begin
        rd_ptr     <= rd_ptr + 1'b1;
        out_valid  <= 1'b1;
        out_instr  <= head;
        out_result <= alu_result;
        out_flags  <= alu_flags;
        retired    <= retired + CNT_W'(1);
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
      // Direct load has priority over writeback to the same register
      if (ld_en && !ld_sel)          reg_a <= ld_data;
      else if (wb_en && !wb_sel)     reg_a <= wb_val;
      if (ld_en && ld_sel)           reg_b <= ld_data;
      else if (wb_en && wb_sel)      reg_b <= wb_val;
    end
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Instruction issue and writeback sequencer for the combinational `alu`. It sits on the requester side of the ALU interface:
- buffers an incoming instruction stream in a small FIFO;
- owns the two architectural registers the ALU reads (address 0 = regA, address 1 = regB);
- drives `instruction`/`regA`/`regB` to the ALU and captures `result`/`flags`;
- writes results back into regA/regB;
- presents each retired instruction on a valid/ready output port.

## Interface
Parameters:
- DEPTH, 4, instruction FIFO entries (power of two, ≥2)
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  FIFO not full
- in_instr  in  32  MIPS instruction word
- ld_en  in  1  direct register load strobe
- ld_sel  in  1  0 = regA, 1 = regB
- ld_data  in  32  load value
- alu_instruction  out  32  to ALU `instruction`
- alu_regA  out  32  to ALU `regA`
- alu_regB  out  32  to ALU `regB`
- alu_result  in  32  from ALU `result`
- alu_flags  in  3  from ALU `flags` ([2] zero, [1] negative, [0] overflow)
- out_valid  out  1  retired entry held
- out_ready  in  1  consumer accepts
- out_instr  out  32  retired instruction
- out_result  out  32  captured ALU result
- out_flags  out  3  captured ALU flags
- reg_a, reg_b  out  32 each  current register contents
- retired  out  CNT_W  count of issued instructions

## Operation
- **Push:** accept when `in_valid && in_ready`; `in_ready = !full`.
- **Issue condition:** `issue = !empty && (!out_valid || out_ready)`.
- **ALU drive:**
  - `alu_instruction` = FIFO head when not empty, else 0.
  - `alu_regA = reg_a`, `alu_regB = reg_b` always.
- **On issue, at the same edge:**
  - pop the FIFO;
  - load the output register with head, `alu_result`, `alu_flags`;
  - set `out_valid`;
  - `retired++`, wrapping at 2^CNT_W.
- **Drain without issue:** on `out_ready && !issue`, clear `out_valid`.
- **Writeback destination:**
  - opcode 000000 writes rd;
  - opcodes 001000–001110 write rt;
  - all other opcodes (beq, bne, lw, sw, unknown) write nothing.
- **Destination filter:** write only if the destination index is 00000 (reg_a) or 00001 (reg_b); other indices are discarded.
- **Writeback value:**
  - slt/sltu (R-type funct 101010/101011) and slti/sltiu (opcode 001010/001011): `{31'b0, alu_flags[1]}`;
  - otherwise `alu_result`.
- **Overflow suppression:** no writeback when `alu_flags[0]=1` for add (funct 100000), sub (funct 100010) or addi (opcode 001000). The entry still retires with flags[0]=1.
- **Load vs. writeback:** if `ld_en` targets the same register as a writeback on the same edge, `ld_en` wins. Different registers both update.
- **Push/pop on one edge:** simultaneous push and pop are legal at any non-full occupancy; occupancy is unchanged.

## Timing
- **Reset (async, rst_n=0):**
  - FIFO empty; `in_ready`=1;
  - `out_valid`=0; `out_instr`/`out_result`/`out_flags`=0;
  - `reg_a`=`reg_b`=0; `retired`=0;
  - `alu_instruction`=0.
- **Mid-operation reset:** discards FIFO contents and the held output immediately; no partial writeback.
- **Latency:** an instruction pushed at edge k (empty FIFO, output free) issues and is captured at edge k+1; `out_valid`=1 after k+1.
- **Throughput:** one instruction per cycle when `out_ready` is held high.
- **No hazards:** writeback happens at the issue edge, so the next instruction (issued at k+2) sees the updated register.
- **Backpressure:** `out_valid && !out_ready` stalls issue. Output fields stay stable until accepted. The FIFO fills; `in_ready` drops after DEPTH accepted instructions.
- **Pointer wrap:** FIFO pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.

## Test plan
- **Load and add:**
  - Stimulus: ld regA=5, regB=7; push add rd=0,rs=0,rt=1 (0x00010020).
  - Response: out_result=12, out_flags=000; reg_a=12 one cycle after push+1.
- **Overflow on add:**
  - Stimulus: regA=0x7FFFFFFF, regB=1; push add rd=0.
  - Response: out_result=0x80000000, out_flags=001; reg_a unchanged.
- **slti writeback:**
  - Stimulus: regA=0xFFFFFFFF; push slti rt=1,rs=0,imm=0 (0x28010000).
  - Response: out_flags[1]=1; reg_b=1.
- **Backpressure:**
  - Stimulus: hold out_ready=0; push 5 instructions back-to-back (DEPTH=4).
  - Response: in_ready=0 after the 5th accept (4 in FIFO, 1 held); releasing out_ready retires them in order, one per cycle; retired=5.
- **Dependency chain:**
  - Stimulus: regA=1; push addi rt=0,rs=0,imm=1 three times back-to-back.
  - Response: out_result sequence 2, 3, 4; final reg_a=4.
- **Mid-operation reset:**
  - Stimulus: assert rst_n=0 with 3 FIFO entries and out_valid=1.
  - Response: immediately out_valid=0, in_ready=1, reg_a=reg_b=0, retired=0; no stale entries after rst_n=1.
